// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: 15-entry architectural register file with two
// asynchronous read ports, E/M write ports, sticky status/halt latch and counters.
module writeback_regfile #(
    parameter int unsigned CNT_W     = 32,
    parameter logic [63:0] RSP_RESET = 64'h0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [2:0]       W_stat_i,
    input  logic [3:0]       W_icode_i,
    input  logic [63:0]      W_pc_i,
    input  logic [63:0]      W_valE_i,
    input  logic [63:0]      W_valM_i,
    input  logic [3:0]       W_dstE_i,
    input  logic [3:0]       W_dstM_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    output logic [63:0]      d_rvalA_o,
    output logic [63:0]      d_rvalB_o,
    input  logic [3:0]       dbg_addr_i,
    output logic [63:0]      dbg_data_o,
    output logic [2:0]       stat_o,
    output logic             halted_o,
    output logic [63:0]      fault_pc_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] cycles_o
);

    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_HLT  = 3'd2;
    localparam logic [2:0] STAT_INS  = 3'd4;
    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        stat_q, stat_d;
    logic [63:0]       fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [63:0]       regs_q [15];
    logic [63:0]       regs_d [15];
    logic              wr_ok_s;
    logic              fault_s;
    logic              retire_s;

    // Status/halt FSM and saturating counters; STOP freezes everything until reset.
    always_comb begin
        state_d    = state_q;
        stat_d     = stat_q;
        fault_pc_d = fault_pc_q;
        retired_d  = retired_q;
        cycles_d   = cycles_q;
        wr_ok_s    = 1'b0;
        fault_s    = 1'b0;
        retire_s   = 1'b0;
        case (state_q)
            RUN: begin
                wr_ok_s  = (W_stat_i == STAT_AOK);
                fault_s  = (W_stat_i >= STAT_HLT);
                retire_s = (wr_ok_s && (W_icode_i != ICODE_NOP)) || (W_stat_i == STAT_HLT);
                if (cycles_q != CNT_MAX) begin
                    cycles_d = cycles_q + CNT_ONE;
                end else begin
                    cycles_d = cycles_q;
                end
                if (retire_s && (retired_q != CNT_MAX)) begin
                    retired_d = retired_q + CNT_ONE;
                end else begin
                    retired_d = retired_q;
                end
                if (fault_s) begin
                    state_d    = STOP;
                    stat_d     = (W_stat_i > STAT_INS) ? STAT_INS : W_stat_i;
                    fault_pc_d = W_pc_i;
                end else begin
                    state_d    = RUN;
                    stat_d     = STAT_AOK;
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = STOP;
            end
        endcase
    end

    // Register-file next state; the M port takes priority when both target one entry.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            if (wr_ok_s && (W_dstM_i == 4'(i))) begin
                regs_d[i] = W_valM_i;
            end else if (wr_ok_s && (W_dstE_i == 4'(i))) begin
                regs_d[i] = W_valE_i;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RUN;
            stat_q     <= STAT_AOK;
            fault_pc_q <= 64'h0;
            retired_q  <= {CNT_W{1'b0}};
            cycles_q   <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            stat_q     <= stat_d;
            fault_pc_q <= fault_pc_d;
            retired_q  <= retired_d;
            cycles_q   <= cycles_d;
        end
    end

    // Architectural register storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == 4) ? RSP_RESET : 64'h0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // No write bypass: decode forwards from W on its own.
    assign d_rvalA_o  = (d_srcA_i   == REG_NONE) ? 64'h0 : regs_q[d_srcA_i];
    assign d_rvalB_o  = (d_srcB_i   == REG_NONE) ? 64'h0 : regs_q[d_srcB_i];
    assign dbg_data_o = (dbg_addr_i == REG_NONE) ? 64'h0 : regs_q[dbg_addr_i];

    assign stat_o     = stat_q;
    assign halted_o   = (state_q == STOP);
    assign fault_pc_o = fault_pc_q;
    assign retired_o  = retired_q;
    assign cycles_o   = cycles_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed literal checks followed by randomized
// traffic compared every cycle against a behavioural register-file model.
module tb_writeback_regfile;

    localparam int unsigned CNT_W = 32;
    localparam logic [63:0] RSP   = 64'h0000_0000_0000_F000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [2:0]       W_stat;
    logic [3:0]       W_icode;
    logic [63:0]      W_pc, W_valE, W_valM;
    logic [3:0]       W_dstE, W_dstM;
    logic [3:0]       d_srcA, d_srcB, dbg_addr;
    logic [63:0]      d_rvalA, d_rvalB, dbg_data;
    logic [2:0]       stat;
    logic             halted;
    logic [63:0]      fault_pc;
    logic [CNT_W-1:0] retired, cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_regfile #(.CNT_W(CNT_W), .RSP_RESET(RSP)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .W_stat_i(W_stat), .W_icode_i(W_icode), .W_pc_i(W_pc),
        .W_valE_i(W_valE), .W_valM_i(W_valM), .W_dstE_i(W_dstE), .W_dstM_i(W_dstM),
        .d_srcA_i(d_srcA), .d_srcB_i(d_srcB), .d_rvalA_o(d_rvalA), .d_rvalB_o(d_rvalB),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data),
        .stat_o(stat), .halted_o(halted), .fault_pc_o(fault_pc),
        .retired_o(retired), .cycles_o(cycles)
    );

    // Behavioural model state.
    logic [63:0] m_reg [15];
    logic [2:0]  m_stat;
    logic        m_halt;
    logic [63:0] m_fpc;
    int unsigned m_ret, m_cyc;

    function automatic logic [63:0] m_read(input logic [3:0] a);
        return (a == 4'hF) ? 64'h0 : m_reg[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: machine running or stopped; AOK writes E then M, HLT retires and stops, faults stop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) m_reg[i] <= (i == 4) ? RSP : 64'h0;
            m_stat <= 3'd1;
            m_halt <= 1'b0;
            m_fpc  <= 64'h0;
            m_ret  <= 0;
            m_cyc  <= 0;
        end else if (!m_halt) begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc <= m_cyc + 1;
            case (W_stat)
                3'd0: ;
                3'd1: begin
                    if (W_dstE != 4'hF) m_reg[W_dstE] <= W_valE;
                    if (W_dstM != 4'hF) m_reg[W_dstM] <= W_valM;
                    if (W_icode != 4'h1 && m_ret != 32'hFFFF_FFFF) m_ret <= m_ret + 1;
                end
                3'd2: begin
                    if (m_ret != 32'hFFFF_FFFF) m_ret <= m_ret + 1;
                    m_halt <= 1'b1;
                    m_stat <= 3'd2;
                    m_fpc  <= W_pc;
                end
                default: begin
                    m_halt <= 1'b1;
                    m_stat <= (W_stat > 3'd4) ? 3'd4 : W_stat;
                    m_fpc  <= W_pc;
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_stat !== 3'bx) begin
            chk("rvalA",   d_rvalA, m_read(d_srcA));
            chk("rvalB",   d_rvalB, m_read(d_srcB));
            chk("dbg",     dbg_data, m_read(dbg_addr));
            chk("stat",    64'(stat), 64'(m_stat));
            chk("halted",  64'(halted), 64'(m_halt));
            chk("faultpc", fault_pc, m_fpc);
            chk("retired", 64'(retired), 64'(m_ret));
            chk("cycles",  64'(cycles), 64'(m_cyc));
        end
    end

    task automatic setw(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] pc,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] de, input logic [3:0] dm);
        W_stat = st; W_icode = ic; W_pc = pc; W_valE = ve; W_valM = vm; W_dstE = de; W_dstM = dm;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        setw(3'd0, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        d_srcA = 4'hF; d_srcB = 4'hF; dbg_addr = 4'h0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk("rst_dbg", dbg_data, (i == 4) ? RSP : 64'h0);
        end
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_faultpc", fault_pc, 64'h0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        cyc();
        rst_n = 1'b1;

        // AOK ALU write to reg2; the read shows the old value until the edge.
        setw(3'd1, 4'h6, 64'h10, 64'h15, 64'h0, 4'h2, 4'hF);
        d_srcA = 4'h2;
        #1;
        chk("pre_edge_read", d_rvalA, 64'h0);
        cyc();
        chk("opq_write", d_rvalA, 64'h15);
        chk("opq_retired", 64'(retired), 64'd1);
        chk("opq_cycles", 64'(cycles), 64'd1);

        // popq %rsp style: both ports target reg4, M wins.
        setw(3'd1, 4'hB, 64'h20, 64'h100, 64'hABCD, 4'h4, 4'h4);
        d_srcB = 4'h4;
        cyc();
        chk("m_priority", d_rvalB, 64'hABCD);
        chk("popq_retired", 64'(retired), 64'd2);

        // Bubbles never write nor retire, but cycles advance.
        setw(3'd0, 4'h1, 64'h30, 64'h99, 64'h0, 4'h5, 4'hF);
        dbg_addr = 4'h5;
        repeat (3) cyc();
        chk("bub_reg5", dbg_data, 64'h0);
        chk("bub_retired", 64'(retired), 64'd2);
        chk("bub_cycles", 64'(cycles), 64'd5);

        // ADR fault: no write, sticky stop, counters freeze.
        setw(3'd3, 4'h5, 64'h40, 64'h7, 64'h0, 4'h3, 4'hF);
        dbg_addr = 4'h3;
        cyc();
        chk("adr_reg3", dbg_data, 64'h0);
        chk("adr_stat", 64'(stat), 64'd3);
        chk("adr_halted", 64'(halted), 64'd1);
        chk("adr_faultpc", fault_pc, 64'h40);
        chk("adr_retired", 64'(retired), 64'd2);
        chk("adr_cycles", 64'(cycles), 64'd6);
        setw(3'd1, 4'h6, 64'h48, 64'h55, 64'h0, 4'h3, 4'hF);
        repeat (2) cyc();
        chk("stop_nowrite", dbg_data, 64'h0);
        chk("stop_cycles", 64'(cycles), 64'd6);
        chk("stop_stat", 64'(stat), 64'd3);

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        #1;
        chk("arst_stat", 64'(stat), 64'd1);
        chk("arst_halted", 64'(halted), 64'd0);
        chk("arst_faultpc", fault_pc, 64'h0);
        chk("arst_retired", 64'(retired), 64'd0);
        chk("arst_cycles", 64'(cycles), 64'd0);
        chk("arst_reg4", d_rvalB, RSP);
        chk("arst_reg2", d_rvalA, 64'h0);
        setw(3'd0, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        rst_n = 1'b1;
        cyc();

        // HLT retires and stops.
        setw(3'd2, 4'h0, 64'h88, 64'h0, 64'h0, 4'hF, 4'hF);
        cyc();
        chk("hlt_stat", 64'(stat), 64'd2);
        chk("hlt_retired", 64'(retired), 64'd1);
        chk("hlt_halted", 64'(halted), 64'd1);
        chk("hlt_faultpc", fault_pc, 64'h88);
        chk("hlt_cycles", 64'(cycles), 64'd2);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;

        // Randomized traffic; restart with reset at random once stopped.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      W_stat = 3'd1;
            else if (r < 95) W_stat = 3'd0;
            else if (r < 97) W_stat = 3'd2;
            else             W_stat = 3'($urandom_range(3, 7));
            W_icode = 4'($urandom);
            W_pc    = {$urandom, $urandom};
            W_valE  = {$urandom, $urandom};
            W_valM  = {$urandom, $urandom};
            W_dstE  = 4'($urandom);
            W_dstM  = ($urandom_range(0, 3) == 0) ? W_dstE : 4'($urandom);
            d_srcA  = 4'($urandom);
            d_srcB  = 4'($urandom);
            dbg_addr = 4'($urandom);
            cyc();
            if (halted && $urandom_range(0, 3) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage of the Y86-64 pipeline. It consumes the outputs of the memory_access-to-W pipeline register.
- Owns the 15-entry architectural register file: two asynchronous read ports feed decode, and two write ports (E and M) are driven from W.
- Holds the sticky processor status and halt latch.
- Keeps retired-instruction and cycle counters for bench and debug visibility.

Parameters:
- CNT_W, 32, width of the retired and cycle counters.
- RSP_RESET, 64'h0, reset value of register 4 (%rsp). All other registers reset to 0.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- W_stat_i  input  3  status of the instruction in W (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS).
- W_icode_i  input  4  icode in W.
- W_pc_i  input  64  PC in W; latched on a fault.
- W_valE_i  input  64  ALU result.
- W_valM_i  input  64  memory read result.
- W_dstE_i  input  4  E write destination; 4'hF = none.
- W_dstM_i  input  4  M write destination; 4'hF = none.
- d_srcA_i  input  4  decode read address A.
- d_srcB_i  input  4  decode read address B.
- d_rvalA_o  output  64  register value for srcA.
- d_rvalB_o  output  64  register value for srcB.
- dbg_addr_i  input  4  debug read address.
- dbg_data_o  output  64  debug read data.
- stat_o  output  3  processor status.
- halted_o  output  1  pipeline stopped; retirement frozen.
- fault_pc_o  output  64  PC of the instruction that stopped the machine.
- retired_o  output  CNT_W  retired-instruction count.
- cycles_o  output  CNT_W  cycles since reset while not halted.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - registers 0-14 = 0, except reg4 = RSP_RESET;
  - stat_o=1 (AOK), halted_o=0, fault_pc_o=0, retired_o=0, cycles_o=0.
  - Reset asserted mid-operation clears everything immediately, with no clock required.
- Reads are combinational:
  - address 4'hF returns 0;
  - there is no write-to-read bypass: a read in the same cycle as a write returns the old value until the edge. Decode forwards from W itself.
  - dbg port obeys the same rules.
- Write enable:
  - wr_ok = (W_stat_i==AOK) && !halted_o.
  - On the edge with wr_ok: if W_dstE_i!=F, reg[W_dstE_i]<=W_valE_i; if W_dstM_i!=F, reg[W_dstM_i]<=W_valM_i.
  - When W_dstE_i==W_dstM_i!=F, the M write wins (popq %rsp semantics).
  - BUB, HLT, ADR and INS never write.
- Status/halt state machine, states RUN and STOP:
  - RUN -> STOP on an edge where W_stat_i is in {2,3,4}: stat_o<=W_stat_i, fault_pc_o<=W_pc_i, halted_o<=1.
  - RUN: W_stat_i of 0 or 1 keeps stat_o=1.
  - STOP is sticky until reset; W inputs are ignored, with no writes and no counting. Status codes 5-7 are treated as INS (stat_o<=4).
- retired_o:
  - +1 on an edge in RUN when W_stat_i==AOK && W_icode_i!=1 (nop), or when W_stat_i==HLT (halt retires).
  - ADR/INS faults do not count; bubbles (stat 0) do not count.
  - Saturates at all-ones.
- cycles_o: +1 every edge while in RUN, including the edge that enters STOP; saturating.
- Latency:
  - writes are visible on read ports immediately after the edge;
  - status and counters update on the same edge.

Test Plan:
- Reset, then read all 15 registers via dbg: zero except reg4=RSP_RESET. stat_o=1, halted_o=0, counters 0; reading reg F returns 0.
- W: stat=1, icode=6, dstE=2, valE=64'h15, dstM=F. After one edge d_rvalA_o (srcA=2)=64'h15 and retired_o=1; before the edge the read returns the old value 0.
- W: stat=1, icode=B, dstE=4, valE=64'h100, dstM=4, valM=64'hABCD. After the edge reg4=64'hABCD (M priority).
- W: stat=3 (ADR), pc=64'h40, dstE=3, valE=7. After the edge reg3 is unchanged, stat_o=3, halted_o=1, fault_pc_o=64'h40, retired_o is not incremented. Later AOK writes are ignored and cycles_o is frozen.
- W: stat=2 (HLT). After the edge stat_o=2, retired_o+1, halted_o=1. Then assert rst_n_i low between edges: all outputs return to reset values asynchronously.
- Bubble (stat=0, icode=1, dstE=5) for 3 cycles: no write to reg5, retired_o unchanged, cycles_o+3.
